servo_pwm: RTL and testbench

SERVO_PWM -- requirements
Module: servo_pwm

---
 rtl/servo_pwm.sv | 133 +++++++++++++
 tb/tb_servo_pwm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm.sv
// -----------------------------------------------------------------------------
// servo_pwm -- multi-channel RC servo pulse generator
//
// A prescaler divides clk into PWM ticks; a frame counter counts ticks per
// frame. Each channel emits one pulse per frame, 256..511 ticks wide
// (1 ms .. ~2 ms at the nominal clock). The pulse width is taken from a shadow
// register that loads pos_in only at the frame boundary, so changes to pos_in
// never produce runt or stretched pulses. All channels rise together.
//
// Optional feature: define SERVO_PWM_LIMIT_EN to clamp each loaded position
// to [POS_MIN, POS_MAX]. With the macro undefined, positions load unmodified.
//
// Parameters:
//   NUM_SERVOS  - number of channels
//   TICK_DIV    - clk cycles per PWM tick
//   FRAME_TICKS - ticks per frame (must be > 511)
//   POS_MIN     - lower clamp limit (SERVO_PWM_LIMIT_EN only)
//   POS_MAX     - upper clamp limit (SERVO_PWM_LIMIT_EN only)
//
// Ports:
//   clk         in   1             rising-edge clock
//   rst         in   1             synchronous active-high reset
//   pos_in      in   8*NUM_SERVOS  positions, channel i in [8i+7:8i]
//   pwm_out     out  NUM_SERVOS    registered servo pulses
//   frame_start out  1             registered one-clk frame boundary pulse
// -----------------------------------------------------------------------------
module servo_pwm #(
    parameter int NUM_SERVOS  = 1,
    parameter int TICK_DIV    = 250,
    parameter int FRAME_TICKS = 5120,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [8*NUM_SERVOS-1:0] pos_in,
    output logic [NUM_SERVOS-1:0]   pwm_out,
    output logic                    frame_start
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FC_W  = $clog2(FRAME_TICKS);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_TICKS - 1);
    localparam logic [7:0]       POS_LO   = 8'(POS_MIN);
    localparam logic [7:0]       POS_HI   = 8'(POS_MAX);
    localparam logic [7:0]       POS_RST  = 8'd127;

    // Saturate a position into [POS_LO, POS_HI].
    function automatic logic [7:0] clamp_pos(input logic [7:0] p);
        logic [7:0] r;
        r = p;
        if (r < POS_LO) r = POS_LO;
        if (r > POS_HI) r = POS_HI;
        return r;
    endfunction

    // Value that enters the shadow register for one channel.
    function automatic logic [7:0] load_pos(input logic [7:0] p);
`ifdef SERVO_PWM_LIMIT_EN
        return clamp_pos(p);
`else
        return p;
`endif
    endfunction

    logic [PRE_W-1:0]          pre_q, pre_d;
    logic [FC_W-1:0]           fc_q, fc_d;
    logic [8*NUM_SERVOS-1:0]   shd_q, shd_d;
    logic [NUM_SERVOS-1:0]     pwm_out_q, pwm_out_d;
    logic                      wrap_q, wrap_d;
    logic                      frame_start_q, frame_start_d;

    logic                      tick;
    logic                      fc_last;
    logic [FC_W-1:0]           thr;

    always_comb begin
        tick    = (pre_q == PRE_LAST);
        fc_last = (fc_q == FC_LAST);

        pre_d = tick ? '0 : pre_q + PRE_W'(1);

        fc_d = fc_q;
        if (tick) begin
            fc_d = fc_last ? '0 : fc_q + FC_W'(1);
        end

        // Shadow registers change only at the frame boundary, all channels at once.
        shd_d = shd_q;
        if (tick && fc_last) begin
            for (int i = 0; i < NUM_SERVOS; i++) begin
                shd_d[8*i +: 8] = load_pos(pos_in[8*i +: 8]);
            end
        end

        // Threshold 256 + shd is simply {1, shd}: a 9-bit value that cannot overflow.
        thr = '0;
        pwm_out_d = '0;
        for (int i = 0; i < NUM_SERVOS; i++) begin
            thr = {{(FC_W-9){1'b0}}, 1'b1, shd_q[8*i +: 8]};
            pwm_out_d[i] = (fc_q < thr);
        end

        // wrap_q marks the cycle where fc has just become 0; frame_start is
        // registered from it so it lines up with the pulse rising edges.
        wrap_d        = tick && fc_last;
        frame_start_d = wrap_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q         <= '0;
            fc_q          <= '0;
            shd_q         <= {NUM_SERVOS{POS_RST}};
            pwm_out_q     <= '0;
            wrap_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            fc_q          <= fc_d;
            shd_q         <= shd_d;
            pwm_out_q     <= pwm_out_d;
            wrap_q        <= wrap_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pwm_out     = pwm_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_servo_pwm.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm -- scoreboard bench for servo_pwm (2 channels, TICK_DIV=2,
// FRAME_TICKS=5120, POS_MIN=20, POS_MAX=200).
// Expected pulse widths and frame_start flags are queued when stimulus is
// driven; a negedge monitor measures each pulse and compares on its fall.
// -----------------------------------------------------------------------------
module tb_servo_pwm;

    localparam int NS     = 2;
    localparam int TDIV   = 2;
    localparam int FTICKS = 5120;
    localparam int PMIN   = 20;
    localparam int PMAX   = 200;
    localparam int PERIOD = FTICKS * TDIV;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [8*NS-1:0] pos_in = 16'h00FF;
    logic [NS-1:0]   pwm_out;
    logic            frame_start;

    servo_pwm #(
        .NUM_SERVOS (NS),
        .TICK_DIV   (TDIV),
        .FRAME_TICKS(FTICKS),
        .POS_MIN    (PMIN),
        .POS_MAX    (PMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pos_in     (pos_in),
        .pwm_out    (pwm_out),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int q_w0[$];
    int q_w1[$];
    int q_fs[$];

    int ncyc      = 0;
    int last_rise = 0;
    int rise_cnt  = 0;
    int hi_cnt[NS];
    logic [NS-1:0] prev_pwm = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference pulse width in clk for a requested position.
    function automatic int exp_width(input int pos);
        int p;
        p = pos;
`ifdef SERVO_PWM_LIMIT_EN
        if (p < PMIN) p = PMIN;
        if (p > PMAX) p = PMAX;
`endif
        return (256 + p) * TDIV;
    endfunction

    function automatic int pop_w(input int ch);
        int v;
        v = -1;
        if (ch == 0) begin
            if (q_w0.size() > 0) v = q_w0.pop_front();
        end else begin
            if (q_w1.size() > 0) v = q_w1.pop_front();
        end
        return v;
    endfunction

    // Monitor: measure pulses, check rise alignment, frame_start and period.
    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < NS; i++) begin
            if (pwm_out[i] && !prev_pwm[i]) begin
                hi_cnt[i] = 1;
            end else if (pwm_out[i]) begin
                hi_cnt[i] = hi_cnt[i] + 1;
            end else if (prev_pwm[i]) begin
                check_eq((i == 0) ? "width_ch0" : "width_ch1", hi_cnt[i], pop_w(i));
            end
        end
        if ((pwm_out != '0) && (prev_pwm == '0)) begin
            check_eq("rise_sync", pwm_out, 2'b11);
            rise_cnt++;
            if (q_fs.size() > 0) begin
                check_eq("frame_start", frame_start, q_fs.pop_front());
            end else begin
                check_eq("fs_queue", 1, 0);
            end
            if (frame_start) begin
                check_eq("frame_period", ncyc - last_rise, PERIOD);
            end
            last_rise = ncyc;
        end else if (frame_start) begin
            check_eq("fs_stray", frame_start, 1'b0);
        end
        prev_pwm = pwm_out;
    end

    task automatic wait_rises(input int n);
        int budget;
        budget = 0;
        while (rise_cnt < n && budget < PERIOD + 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (rise_cnt < n) check_eq("timeout_rise", rise_cnt, n);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) hi_cnt[i] = 0;

        // Reset state
        step(5);
        check_eq("rst_pwm", pwm_out, 2'b00);
        check_eq("rst_fs", frame_start, 1'b0);

        // Frame 1 runs on reset value 127; frame 2 on pos_in = 00FF.
        q_w0.push_back(exp_width(127));
        q_w1.push_back(exp_width(127));
        q_fs.push_back(0);
        q_w0.push_back(exp_width(255));
        q_w1.push_back(exp_width(0));
        q_fs.push_back(1);
        rst = 1'b0;
        step(1);
        check_eq("release_rise", pwm_out, 2'b11);

        // Mid-pulse of frame 2: ch0 -> 0 must only affect frame 3.
        wait_rises(2);
        step(600);
        pos_in = 16'h0000;
        q_w0.push_back(exp_width(0));
        q_w1.push_back(exp_width(0));
        q_fs.push_back(1);

        // Frame 3: restore ch0 = 255 for frame 4.
        wait_rises(3);
        step(2000);
        pos_in = 16'h00FF;
        q_fs.push_back(1);

        // Frame 4: reset 300 clk into the 1022-clk pulse truncates both channels.
        wait_rises(4);
        q_w0.push_back(300);
        q_w1.push_back(300);
        q_fs.push_back(0);
        q_w0.push_back(exp_width(127));
        q_w1.push_back(exp_width(127));
        step(298);
        rst = 1'b1;
        step(1);
        check_eq("rst_mid_low", pwm_out, 2'b00);
        rst = 1'b0;
        step(1);
        check_eq("rst_mid_rise", pwm_out, 2'b11);

        // Frame 5 (post-reset): load ch0 = 5, ch1 = 250 for frame 6.
        wait_rises(5);
        step(2000);
        pos_in = {8'd250, 8'd5};
        q_w0.push_back(exp_width(5));
        q_w1.push_back(exp_width(250));
        q_fs.push_back(1);

        wait_rises(6);
        step(1200);
        check_eq("q_w0_empty", q_w0.size(), 0);
        check_eq("q_w1_empty", q_w1.size(), 0);
        check_eq("q_fs_empty", q_fs.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
